// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type and byte-level transform helpers
// used by the round datapath and the iterative engine.
package aes_pkg;
  localparam int AES_BLOCK_W = 128;
  localparam int AES_KEY_W   = 128;
  localparam int AES_NROUNDS = 10;

  typedef enum logic [1:0] {IDLE, RUN, DONE} aes_state_e;

  function automatic bit unroll_legal(input int unroll);
    return (unroll == 1) || (unroll == 2) || (unroll == 5) || (unroll == 10);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box computed as the GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y, b;
    y = x;
    for (int i = 0; i < 6; i++) y = gf_mul(gf_mul(y, y), x);
    b = gf_mul(y, y);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rc);
    case (rc)
      4'd0: return 8'h01;
      4'd1: return 8'h02;
      4'd2: return 8'h04;
      4'd3: return 8'h08;
      4'd4: return 8'h10;
      4'd5: return 8'h20;
      4'd6: return 8'h40;
      4'd7: return 8'h80;
      4'd8: return 8'h1b;
      4'd9: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // Column-major state: byte 4c+r sits at row r, column c.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [3:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rcon(rc), 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction
endpackage

// File: rtl/aes_round_chain.sv
// Combinational chain of UNROLL round slots starting at round index rnd;
// a slot landing on round 9 selects the last-round datapath.
module aes_round_chain
  import aes_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic [AES_BLOCK_W-1:0] st,
  input  logic [AES_KEY_W-1:0]   key,
  input  logic [3:0]             rnd,
  output logic [AES_BLOCK_W-1:0] st_next,
  output logic [AES_KEY_W-1:0]   key_next,
  output logic [AES_BLOCK_W-1:0] final_out
);
  for (genvar i = 0; i < UNROLL; i++) begin : g_slot
    logic [3:0]             r;
    logic [AES_BLOCK_W-1:0] d_in, d_mid, d_last, d_o;
    logic [AES_KEY_W-1:0]   k_in, k_mid, k_last, k_o;

    if (i == 0) begin : g_head
      assign d_in = st;
      assign k_in = key;
    end else begin : g_link
      assign d_in = g_slot[i-1].d_o;
      assign k_in = g_slot[i-1].k_o;
    end

    assign r = rnd + 4'(i);

    round u_round (.data(d_in), .key(k_in), .rc(r), .data_out(d_mid), .key_out(k_mid));
    last_round u_last (.data(d_in), .key(k_in), .rc(r), .data_out(d_last), .key_out(k_last));

    assign d_o = (r == 4'd9) ? d_last : d_mid;
    assign k_o = (r == 4'd9) ? k_last : k_mid;
  end

  assign st_next   = g_slot[UNROLL-1].d_o;
  assign key_next  = g_slot[UNROLL-1].k_o;
  assign final_out = g_slot[UNROLL-1].d_o;
endmodule

// File: rtl/last_round.sv
// Final AES round: identical to a normal round but without MixColumns.
module last_round
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] data,
  input  logic [AES_KEY_W-1:0]   key,
  input  logic [3:0]             rc,
  output logic [AES_BLOCK_W-1:0] data_out,
  output logic [AES_KEY_W-1:0]   key_out
);
  assign key_out  = next_key(key, rc);
  assign data_out = shift_rows(sub_bytes(data)) ^ key_out;
endmodule

// File: rtl/round.sv
// One full AES round with on-the-fly expansion of the next round key.
module round
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] data,
  input  logic [AES_KEY_W-1:0]   key,
  input  logic [3:0]             rc,
  output logic [AES_BLOCK_W-1:0] data_out,
  output logic [AES_KEY_W-1:0]   key_out
);
  assign key_out  = next_key(key, rc);
  assign data_out = mix_columns(shift_rows(sub_bytes(data))) ^ key_out;
endmodule

// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryptor, UNROLL rounds per clock, valid/ready on both sides.
// state | meaning
// IDLE  | waiting for a block; RUN | rounds in progress; DONE | ciphertext held until out_ready
module aes128_encrypt_iter
  import aes_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] data_in,
  input  logic [AES_KEY_W-1:0]   key,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] data_out,
  output logic                   busy
);
  localparam int         NCYC     = AES_NROUNDS / UNROLL;
  localparam logic [3:0] STEP     = 4'(UNROLL);
  localparam logic [3:0] LAST_RND = 4'(AES_NROUNDS - UNROLL);

  if (!unroll_legal(UNROLL) || (NCYC * UNROLL != AES_NROUNDS)) begin : g_bad_unroll
    $error("aes128_encrypt_iter: UNROLL must be 1, 2, 5 or 10");
  end

  aes_state_e             state_q, state_d;
  logic [AES_BLOCK_W-1:0] st_q, chain_st, chain_final;
  logic [AES_KEY_W-1:0]   key_q, chain_key;
  logic [3:0]             rnd_q;
  logic                   accept, last_cyc;

  aes_round_chain #(.UNROLL(UNROLL)) u_chain (
    .st       (st_q),
    .key      (key_q),
    .rnd      (rnd_q),
    .st_next  (chain_st),
    .key_next (chain_key),
    .final_out(chain_final)
  );

  assign in_ready = rst_n & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
  assign accept   = in_valid & in_ready;
  assign last_cyc = (state_q == RUN) & (rnd_q == LAST_RND);
  assign busy     = (state_q == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_cyc) state_d = DONE;
      DONE:    if (out_ready) state_d = in_valid ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= '0;
      key_q     <= '0;
      rnd_q     <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        st_q  <= data_in ^ key;
        key_q <= key;
        rnd_q <= '0;
      end else if (state_q == RUN) begin
        st_q  <= chain_st;
        key_q <= chain_key;
        rnd_q <= rnd_q + STEP;
      end
      // data_out is only ever written with a finished ciphertext
      if (last_cyc) begin
        data_out  <= chain_final;
        out_valid <= 1'b1;
      end else if ((state_q == DONE) && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Directed bench for aes128_encrypt_iter: one instance per legal UNROLL,
// FIPS-197 vectors, latency, backpressure, streaming, reset and random handshakes.
module tb_aes128_encrypt_iter;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_Z  = 128'h0;
  localparam logic [127:0] K_Z   = 128'h0;
  localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam int           N_RND = 120;

  logic         clk;
  logic         rst_n;
  logic [127:0] data_in, key;
  logic [3:0]   in_valid, out_ready, in_ready, out_valid, busy;
  logic [127:0] dout [4];

  logic [127:0] vec_pt  [3];
  logic [127:0] vec_key [3];
  logic [127:0] vec_ct  [3];
  int           lat_tab [4];

  int           n_err, n_chk;
  logic [127:0] sb [$];
  logic [127:0] exp_pend;
  int           n_in, n_out, cyc, v, lat, rdy_bad;
  bit           pend;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  aes128_encrypt_iter #(.UNROLL(1)) u_u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .data_in(data_in), .key(key), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .data_out(dout[0]), .busy(busy[0]));
  aes128_encrypt_iter #(.UNROLL(2)) u_u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .data_in(data_in), .key(key), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .data_out(dout[1]), .busy(busy[1]));
  aes128_encrypt_iter #(.UNROLL(5)) u_u5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .data_in(data_in), .key(key), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .data_out(dout[2]), .busy(busy[2]));
  aes128_encrypt_iter #(.UNROLL(10)) u_u10 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .data_in(data_in), .key(key), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
    .data_out(dout[3]), .busy(busy[3]));

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at the negedge where the handshake is presented; lat counts from there.
  task automatic wait_out(input int idx, input logic [127:0] exp_ct, input int exp_lat,
                          input bit hold, input string tag);
    int l, bcnt;
    @(negedge clk);
    if (!hold) in_valid[idx] = 1'b0;
    l    = 1;
    bcnt = 0;
    while (!out_valid[idx] && l < 40) begin
      if (busy[idx]) bcnt++;
      @(negedge clk);
      l++;
    end
    check_eq({tag, "_lat"}, 128'(l), 128'(exp_lat));
    check_eq({tag, "_busy"}, 128'(bcnt), 128'(exp_lat - 1));
    check_eq({tag, "_ct"}, dout[idx], exp_ct);
  endtask

  task automatic run_block(input int idx, input logic [127:0] pt, input logic [127:0] k,
                           input logic [127:0] ct, input int exp_lat, input string tag);
    @(negedge clk);
    data_in       = pt;
    key           = k;
    in_valid[idx] = 1'b1;
    #1 check_eq({tag, "_rdy"}, 128'(in_ready[idx]), 128'd1);
    wait_out(idx, ct, exp_lat, 1'b0, tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_err = 0; n_chk = 0;
    vec_pt  = '{PT_C1, PT_B, PT_Z};
    vec_key = '{K_C1, K_B, K_Z};
    vec_ct  = '{CT_C1, CT_B, CT_Z};
    lat_tab = '{11, 6, 3, 2};
    rst_n = 1'b0; in_valid = '0; out_ready = '0; data_in = '0; key = '0;

    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("rst_in_ready_%0d", i), 128'(in_ready[i]), 128'd0);
      check_eq($sformatf("rst_out_valid_%0d", i), 128'(out_valid[i]), 128'd0);
      check_eq($sformatf("rst_data_out_%0d", i), dout[i], 128'd0);
      check_eq($sformatf("rst_busy_%0d", i), 128'(busy[i]), 128'd0);
    end
    rst_n     = 1'b1;
    out_ready = 4'hF;

    run_block(0, PT_C1, K_C1, CT_C1, 11, "c1_u1");
    for (int i = 0; i < 4; i++)
      run_block(i, PT_B, K_B, CT_B, lat_tab[i], $sformatf("b_idx%0d", i));
    run_block(2, PT_Z, K_Z, CT_Z, 3, "zero_u5");
    @(negedge clk);
    check_eq("ov_drop_u5", 128'(out_valid[2]), 128'd0);
    check_eq("dout_hold_u5", dout[2], CT_Z);

    // Backpressure on UNROLL=1, with a second block offered during RUN
    out_ready[0] = 1'b0;
    @(negedge clk);
    data_in = PT_C1; key = K_C1; in_valid[0] = 1'b1;
    #1 check_eq("bp_rdy", 128'(in_ready[0]), 128'd1);
    @(negedge clk);
    data_in = PT_B; key = K_B;
    lat = 1; rdy_bad = 0;
    while (!out_valid[0] && lat < 40) begin
      if (in_ready[0]) rdy_bad++;
      @(negedge clk);
      lat++;
    end
    check_eq("bp_lat", 128'(lat), 128'd11);
    check_eq("bp_run_rdy", 128'(rdy_bad), 128'd0);
    for (int i = 0; i < 20; i++) begin
      check_eq("bp_hold_ct", dout[0], CT_C1);
      check_eq("bp_hold_ov", 128'(out_valid[0]), 128'd1);
      check_eq("bp_hold_rdy", 128'(in_ready[0]), 128'd0);
      @(negedge clk);
    end
    out_ready[0] = 1'b1;
    #1 check_eq("bp_handoff_rdy", 128'(in_ready[0]), 128'd1);
    wait_out(0, CT_B, 11, 1'b0, "bp_handoff");

    // Back-to-back streaming on UNROLL=2 with in_valid held high
    @(negedge clk);
    for (int s = 0; s < 6; s++) begin
      data_in = vec_pt[s % 2]; key = vec_key[s % 2]; in_valid[1] = 1'b1;
      #1 check_eq("stream_rdy", 128'(in_ready[1]), 128'd1);
      wait_out(1, vec_ct[s % 2], 6, 1'b1, $sformatf("stream%0d", s));
    end
    in_valid[1] = 1'b0;

    // Reset mid-RUN (UNROLL=1 at round 4) and mid-DONE (UNROLL=5 held)
    @(negedge clk);
    data_in = PT_C1; key = K_C1; in_valid[0] = 1'b1; in_valid[2] = 1'b1; out_ready[2] = 1'b0;
    @(negedge clk);
    in_valid[0] = 1'b0; in_valid[2] = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("pre_rst_ov_u5", 128'(out_valid[2]), 128'd1);
    check_eq("pre_rst_busy_u1", 128'(busy[0]), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ov_u1", 128'(out_valid[0]), 128'd0);
    check_eq("mid_rst_dout_u1", dout[0], 128'd0);
    check_eq("mid_rst_busy_u1", 128'(busy[0]), 128'd0);
    check_eq("mid_rst_ov_u5", 128'(out_valid[2]), 128'd0);
    check_eq("mid_rst_dout_u5", dout[2], 128'd0);
    data_in = PT_B; key = K_B; in_valid[3] = 1'b1;
    #1 check_eq("mid_rst_rdy_u10", 128'(in_ready[3]), 128'd0);
    @(negedge clk);
    rst_n = 1'b1; out_ready[2] = 1'b1;
    #1 check_eq("rel_rdy_u10", 128'(in_ready[3]), 128'd1);
    wait_out(3, CT_B, 2, 1'b0, "rst_hold_u10");
    run_block(0, PT_C1, K_C1, CT_C1, 11, "post_rst_u1");

    // Random in_valid/out_ready on UNROLL=2 against a scoreboard of known vectors
    n_in = 0; n_out = 0; cyc = 0; pend = 1'b0;
    @(negedge clk);
    while ((n_in < N_RND || sb.size() != 0) && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (!pend) begin
        in_valid[1] = 1'b0;
        if (n_in < N_RND && $urandom_range(0, 2) != 0) begin
          v = $urandom_range(0, 2);
          data_in = vec_pt[v]; key = vec_key[v]; exp_pend = vec_ct[v];
          in_valid[1] = 1'b1;
          pend = 1'b1;
        end
      end
      out_ready[1] = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid[1] && out_ready[1]) begin
        check_eq("rnd_extra", 128'(sb.size() != 0), 128'd1);
        if (sb.size() != 0) check_eq("rnd_ct", dout[1], sb.pop_front());
        n_out++;
      end
      if (in_valid[1] && in_ready[1]) begin
        sb.push_back(exp_pend);
        n_in++;
        pend = 1'b0;
      end
    end
    in_valid[1] = 1'b0;
    check_eq("rnd_n_in", 128'(n_in), 128'(N_RND));
    check_eq("rnd_n_out", 128'(n_out), 128'(n_in));
    check_eq("rnd_drain", 128'(sb.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
